// File: rtl/flag_branch_if.sv
// flag_branch_if
//   Groups the signals between the compare stage / branch requester and the
//   flag branch unit.
//   master : requester side - drives flags, branch request, target PCs;
//            observes the handshake, resolution, redirect and flush.
//   slave  : flag_branch_unit side - the mirror image of master.
//   Signals:
//     flags_in/flags_we  flag vector {N,Z,C,V} and its load strobe
//     flags_q            registered flag vector
//     br_valid/br_ready  branch request handshake
//     br_cond            4-bit condition code
//     br_target          taken-path PC
//     br_fallthru        not-taken PC
//     resolve_valid      one-cycle pulse when a branch resolves
//     taken              resolution result, qualified by resolve_valid
//     redirect_valid     one-cycle pulse: fetch loads redirect_pc
//     redirect_pc        next PC of the resolved branch
//     flush              squash younger instructions
interface flag_branch_if;
    logic [3:0]  flags_in;
    logic        flags_we;
    logic [3:0]  flags_q;
    logic        br_valid;
    logic        br_ready;
    logic [3:0]  br_cond;
    logic [31:0] br_target;
    logic [31:0] br_fallthru;
    logic        resolve_valid;
    logic        taken;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;

    modport master (
        output flags_in, flags_we, br_valid, br_cond, br_target, br_fallthru,
        input  flags_q, br_ready, resolve_valid, taken, redirect_valid,
               redirect_pc, flush
    );

    modport slave (
        input  flags_in, flags_we, br_valid, br_cond, br_target, br_fallthru,
        output flags_q, br_ready, resolve_valid, taken, redirect_valid,
               redirect_pc, flush
    );
endinterface

// File: rtl/flag_branch_unit.sv
// flag_branch_unit
//   Latches the {N,Z,C,V} flags from the compare stage, evaluates a 4-bit
//   condition code against them and resolves conditional branches through a
//   valid/ready handshake. A taken branch produces a PC redirect and a flush
//   held for FLUSH_CYCLES cycles (counting the resolve cycle). Saturating
//   counters track taken and resolved branches.
//   Ports:
//     clk           rising-edge clock
//     rst           asynchronous, active-high reset
//     bus           flag_branch_if.slave (flags, request, resolution, flush)
//     taken_cnt     saturating count of taken branches
//     resolved_cnt  saturating count of all resolved branches
module flag_branch_unit #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    flag_branch_if.slave     bus,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] resolved_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECIDE = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    // Flush is asserted on the resolve cycle only when FLUSH_CYCLES > 0; the
    // FLUSH state is entered only when more than one cycle is required.
    localparam logic       FLUSH_EN   = (FLUSH_CYCLES > 0) ? 1'b1 : 1'b0;
    localparam logic       FLUSH_EXT  = (FLUSH_CYCLES > 1) ? 1'b1 : 1'b0;
    // FLUSH state cycles remaining after the first one.
    localparam logic [3:0] FLUSH_HOLD = (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 2) : 4'd0;

    state_t            state_r;
    logic [3:0]        flush_cnt_r;
    logic [3:0]        flags_r;
    logic              ready_r;
    logic              resolve_valid_r;
    logic              taken_r;
    logic              redirect_valid_r;
    logic [31:0]       redirect_pc_r;
    logic              flush_r;
    logic [CNT_W-1:0]  taken_cnt_r;
    logic [CNT_W-1:0]  resolved_cnt_r;

    logic [3:0]        eff_flags_s;
    logic              cond_s;
    logic              accept_s;

    // Condition evaluation on flags {N,Z,C,V}.
    function automatic logic cond_eval(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, c, v;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cc)
            4'd0:    return z;
            4'd1:    return ~z;
            4'd2:    return c;
            4'd3:    return ~c;
            4'd4:    return n;
            4'd5:    return ~n;
            4'd6:    return v;
            4'd7:    return ~v;
            4'd8:    return c & ~z;
            4'd9:    return ~c | z;
            4'd10:   return n ~^ v;
            4'd11:   return n ^ v;
            4'd12:   return ~z & (n ~^ v);
            4'd13:   return z | (n ^ v);
            4'd14:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Saturating increment: stays at all-ones once reached.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        if (&val) begin
            return val;
        end else begin
            return val + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Effective flags with same-cycle bypass, condition result and accept.
    always_comb begin
        eff_flags_s = flags_r;
        if (bus.flags_we) begin
            eff_flags_s = bus.flags_in;
        end else begin
            eff_flags_s = flags_r;
        end
        cond_s   = cond_eval(bus.br_cond, eff_flags_s);
        accept_s = bus.br_valid & ready_r;
    end

    // Flag register: loads whenever flags_we is set, independent of the FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_r <= 4'd0;
        end else if (bus.flags_we) begin
            flags_r <= bus.flags_in;
        end else begin
            flags_r <= flags_r;
        end
    end

    // Branch FSM with registered handshake, resolution, redirect and flush.
    // The resolution outputs are computed at accept so they are registered
    // when DECIDE begins; later flag writes cannot disturb them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r          <= IDLE;
            flush_cnt_r      <= 4'd0;
            ready_r          <= 1'b1;
            resolve_valid_r  <= 1'b0;
            taken_r          <= 1'b0;
            redirect_valid_r <= 1'b0;
            redirect_pc_r    <= 32'd0;
            flush_r          <= 1'b0;
            taken_cnt_r      <= {CNT_W{1'b0}};
            resolved_cnt_r   <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_r          <= DECIDE;
                        ready_r          <= 1'b0;
                        resolve_valid_r  <= 1'b1;
                        taken_r          <= cond_s;
                        redirect_valid_r <= cond_s;
                        redirect_pc_r    <= cond_s ? bus.br_target : bus.br_fallthru;
                        flush_r          <= cond_s & FLUSH_EN;
                        resolved_cnt_r   <= sat_inc(resolved_cnt_r);
                        if (cond_s) begin
                            taken_cnt_r <= sat_inc(taken_cnt_r);
                        end else begin
                            taken_cnt_r <= taken_cnt_r;
                        end
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                DECIDE: begin
                    resolve_valid_r  <= 1'b0;
                    taken_r          <= 1'b0;
                    redirect_valid_r <= 1'b0;
                    if (taken_r && FLUSH_EXT) begin
                        state_r     <= FLUSH;
                        flush_cnt_r <= FLUSH_HOLD;
                    end else begin
                        state_r <= IDLE;
                        ready_r <= 1'b1;
                        flush_r <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (flush_cnt_r == 4'd0) begin
                        state_r <= IDLE;
                        ready_r <= 1'b1;
                        flush_r <= 1'b0;
                    end else begin
                        flush_cnt_r <= flush_cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_r          <= IDLE;
                    ready_r          <= 1'b1;
                    resolve_valid_r  <= 1'b0;
                    taken_r          <= 1'b0;
                    redirect_valid_r <= 1'b0;
                    flush_r          <= 1'b0;
                end
            endcase
        end
    end

    assign bus.flags_q        = flags_r;
    assign bus.br_ready       = ready_r;
    assign bus.resolve_valid  = resolve_valid_r;
    assign bus.taken          = taken_r;
    assign bus.redirect_valid = redirect_valid_r;
    assign bus.redirect_pc    = redirect_pc_r;
    assign bus.flush          = flush_r;
    assign taken_cnt          = taken_cnt_r;
    assign resolved_cnt       = resolved_cnt_r;

endmodule
